fft_sample_loader: RTL
======================

# fft_sample_loader

Parametrised front-end loader for `fft_top`. It accepts a valid-qualified ADC sample stream and writes one FFT frame of BANKS×DEPTH samples into the FFT input RAM banks, in either bank-sequential or interleaved order. When the frame is complete it pulses the FFT start and waits for the FFT ready edge before re-arming. It replaces hand-driven per-bank address/write-enable sequencing and adds flow control and dropped-sample accounting.

## Interface
- DATA_W, 16, ADC sample width (two's complement)
- BANKS, 4, number of FFT input RAM banks (≥1)
- DEPTH, 512, words per bank (power of two)
- ADDR_W, $clog2(DEPTH), bank address width
- INTERLEAVE, 0, 0: fill bank 0 fully, then bank 1, ...; 1: sample n → bank n%BANKS, address n/BANKS
- iCLK  in  1  clock, all logic on rising edge
- iRESET  in  1  asynchronous, active-low reset
- iARM  in  1  one-cycle request to start a new frame; honoured only in IDLE
- iDATA  in  DATA_W  ADC sample
- iVALID  in  1  sample qualifier
- oREADY  out  1  high in FILL; sample accepted on edge where iVALID&oREADY
- oDATA  out  DATA_W  registered sample to RAM write port (shared by all banks)
- oADDR_WR  out  BANKS*ADDR_W  per-bank write address, bank b at bits [b*ADDR_W +: ADDR_W]
- oWE  out  BANKS  per-bank write enable, at most one bit high
- oSTART  out  1  one-cycle FFT launch pulse (to fft_top iSTART)
- iFFT_RDY  in  1  FFT ready level (from fft_top oRDY)
- oBUSY  out  1  high in any state except IDLE
- oDONE  out  1  one-cycle pulse on FFT completion
- oDROP_CNT  out  16  samples presented (iVALID) while oREADY low, saturating

## Operation
- States: IDLE → FILL → LAUNCH → WAIT_FFT → DONE → IDLE.
- IDLE: iARM=1 clears the sample counter n and oDROP_CNT, then moves to FILL.
- FILL: each accepted sample increments n (width $clog2(BANKS*DEPTH)).
  - INTERLEAVE=0: bank = n/DEPTH, addr = n%DEPTH.
  - INTERLEAVE=1: bank = n%BANKS, addr = n/BANKS.
  - When the sample with n = BANKS*DEPTH−1 is accepted, go to LAUNCH.
- LAUNCH: one cycle, then WAIT_FFT.
- WAIT_FFT: iFFT_RDY is sampled every cycle. The first rising edge seen (previous sample 0, current 1) moves to DONE. A level already high on entry is ignored until it has been seen low.
- DONE: one cycle, then IDLE.
- oDROP_CNT increments on every cycle with iVALID=1 and oREADY=0, except in IDLE before the first arm after reset. It saturates at 16'hFFFF.
- iARM outside IDLE is ignored and does not affect oDROP_CNT.
- Bank address fields of banks not being written hold their last written value.

## Timing
- Reset values: oREADY=0, oDATA=0, oADDR_WR=0, oWE=0, oSTART=0, oBUSY=0, oDONE=0, oDROP_CNT=0; state IDLE, n=0, iFFT_RDY history register=1.
- Reset applied mid-frame aborts immediately. No further writes are issued; the RAM keeps its partial contents.
- oREADY is a registered state decode. It is high from the cycle after iARM is sampled until the edge that accepts the final sample.
- Write latency: a sample accepted at edge k appears on oDATA/oADDR_WR/oWE in cycle k+1, with oWE high for exactly one cycle. Back-to-back acceptance gives one write per cycle.
- oSTART is high in the cycle after the final write cycle, i.e. two cycles after the final sample is accepted. It is never concurrent with any oWE bit.
- oDONE goes high one cycle after the iFFT_RDY rising edge is sampled. oBUSY falls in the same cycle oDONE falls.
- Minimum frame time is BANKS*DEPTH + 4 cycles plus the FFT run time.

## Test plan
- Defaults, INTERLEAVE=0, 2048 back-to-back samples of constant 100 → bank 0 addr 0..511 written first, then banks 1, 2, 3. Each RAM word = 100, one oSTART pulse, oDROP_CNT=0.
- INTERLEAVE=1, ramp 0..2047 → bank b addr a holds 4a+b. Sample 2047 lands in bank 3 addr 511.
- iVALID toggling 1/0 during FILL → writes only on accepted cycles, no duplicated or skipped addresses, oSTART two cycles after the last accept.
- 5 cycles of iVALID=1 during WAIT_FFT, plus iARM pulsed there → oDROP_CNT=5, no state change. The next iARM in IDLE clears oDROP_CNT to 0.
- iFFT_RDY held high from LAUNCH, low for 3 cycles, then high → oDONE only after the re-rise, exactly one pulse.
- iRESET low after 300 accepts → all outputs 0 within the reset cycle. After release, iARM restarts the fill at bank 0 addr 0.

Source files
------------

// File: rtl/fft_sample_loader_if.sv
// Sample-stream, RAM write and FFT control bundle for fft_sample_loader.
// master = loader side, slave = ADC/RAM/FFT environment side.
interface fft_sample_loader_if #(
    parameter int DATA_W = 16,
    parameter int BANKS  = 4,
    parameter int ADDR_W = 9
);
    logic                    iARM;
    logic [DATA_W-1:0]       iDATA;
    logic                    iVALID;
    logic                    oREADY;
    logic [DATA_W-1:0]       oDATA;
    logic [BANKS*ADDR_W-1:0] oADDR_WR;
    logic [BANKS-1:0]        oWE;
    logic                    oSTART;
    logic                    iFFT_RDY;
    logic                    oBUSY;
    logic                    oDONE;
    logic [15:0]             oDROP_CNT;

    modport master (
        input  iARM, iDATA, iVALID, iFFT_RDY,
        output oREADY, oDATA, oADDR_WR, oWE,
        output oSTART, oBUSY, oDONE, oDROP_CNT
    );

    modport slave (
        output iARM, iDATA, iVALID, iFFT_RDY,
        input  oREADY, oDATA, oADDR_WR, oWE,
        input  oSTART, oBUSY, oDONE, oDROP_CNT
    );
endinterface

// File: rtl/fft_sample_loader.sv
// Fills BANKS x DEPTH FFT input RAM from a valid-qualified ADC stream,
// launches the FFT and waits for its ready edge before re-arming.
module fft_sample_loader #(
    parameter int DATA_W     = 16,
    parameter int BANKS      = 4,
    parameter int DEPTH      = 512,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int INTERLEAVE = 0
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    fft_sample_loader_if.master  bus
);
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(BANKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [BANK_W-1:0]       r_cnt_bank;
    logic [ADDR_W-1:0]       r_cnt_addr;
    logic [BANK_W-1:0]       w_bank_nxt;
    logic [ADDR_W-1:0]       w_addr_nxt;

    logic                    r_ready;
    logic [DATA_W-1:0]       r_data;
    logic [BANKS*ADDR_W-1:0] r_addr;
    logic [BANKS-1:0]        r_we;
    logic                    r_start;
    logic                    r_busy;
    logic                    r_done;
    logic [15:0]             r_drop;
    logic                    r_armed;
    logic                    r_rdy_hist;

    logic                    w_accept;
    logic                    w_last;
    logic                    w_arm;
    logic                    w_rdy_rise;
    logic                    w_drop_evt;
    logic [BANKS-1:0]        w_sel;

    assign w_accept   = bus.iVALID & r_ready;
    assign w_last     = (r_cnt_bank == LAST_BANK) &&
                        (r_cnt_addr == LAST_ADDR);
    assign w_arm      = (r_state == S_IDLE) & bus.iARM;
    assign w_rdy_rise = bus.iFFT_RDY & ~r_rdy_hist;

    // Drops are only meaningful once a frame has ever been requested
    assign w_drop_evt = bus.iVALID & ~r_ready & r_armed;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.iARM) w_next = S_FILL;
            S_FILL:   if (w_accept && w_last) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   if (w_rdy_rise) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_bank_nxt = r_cnt_bank;
        w_addr_nxt = r_cnt_addr;
        if (INTERLEAVE != 0) begin
            if (r_cnt_bank == LAST_BANK) begin
                w_bank_nxt = '0;
                w_addr_nxt = r_cnt_addr + 1'b1;
            end else begin
                w_bank_nxt = r_cnt_bank + 1'b1;
            end
        end else begin
            if (r_cnt_addr == LAST_ADDR) begin
                w_addr_nxt = '0;
                w_bank_nxt = r_cnt_bank + 1'b1;
            end else begin
                w_addr_nxt = r_cnt_addr + 1'b1;
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int b = 0; b < BANKS; b++) begin
            w_sel[b] = (r_cnt_bank == BANK_W'(b));
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_start    <= 1'b0;
            r_rdy_hist <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_ready    <= (w_next == S_FILL);
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
            r_start    <= (r_state == S_LAUNCH);
            r_rdy_hist <= bus.iFFT_RDY;
        end
    end

    // Sample counter, held as bank/address pair to avoid a divider
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_cnt_bank <= '0;
            r_cnt_addr <= '0;
            r_armed    <= 1'b0;
        end else if (w_arm) begin
            r_cnt_bank <= '0;
            r_cnt_addr <= '0;
            r_armed    <= 1'b1;
        end else if (w_accept) begin
            r_cnt_bank <= w_bank_nxt;
            r_cnt_addr <= w_addr_nxt;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_data <= '0;
            r_addr <= '0;
            r_we   <= '0;
        end else begin
            r_we <= '0;
            if (w_accept) begin
                r_data <= bus.iDATA;
                r_we   <= w_sel;
                for (int b = 0; b < BANKS; b++) begin
                    if (w_sel[b]) begin
                        r_addr[b*ADDR_W +: ADDR_W] <= r_cnt_addr;
                    end
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_drop <= '0;
        end else if (w_arm) begin
            r_drop <= '0;
        end else if (w_drop_evt && (r_drop != 16'hFFFF)) begin
            r_drop <= r_drop + 16'd1;
        end
    end

    assign bus.oREADY    = r_ready;
    assign bus.oDATA     = r_data;
    assign bus.oADDR_WR  = r_addr;
    assign bus.oWE       = r_we;
    assign bus.oSTART    = r_start;
    assign bus.oBUSY     = r_busy;
    assign bus.oDONE     = r_done;
    assign bus.oDROP_CNT = r_drop;
endmodule
